// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M divide/remainder unit (optionally multiply).
//
// Captures both source operands on accept, iterates one bit per cycle for 32
// cycles and presents Rd/RegWrite/WriteData ready for the register file write
// port. Divide-by-zero and signed overflow bypass the iteration and finish in
// the accept cycle.
//
// Build option: define MULDIV_MUL_EN to build the shift-add multiplier for
// funct3 000-011. Without it those encodings finish at once with WriteData=0
// and RegWrite held low.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request, sampled only while not busy
//   funct3            op select (DIV/DIVU/REM/REMU, MUL/MULH/MULHSU/MULHU)
//   Rs1Data, Rs2Data  dividend/multiplicand, divisor/multiplier
//   RdIn              destination register index
//   busy              high while iterating
//   done              one-cycle result-valid pulse
//   Rd, WriteData     destination index and result, valid with done
//   RegWrite          done and Rd != 0 (and the op produces a result)

`timescale 1ns / 1ps

module muldiv_unit #(
    parameter int unsigned XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] Rs1Data,
    input  logic [XLEN-1:0] Rs2Data,
    input  logic [4:0]      RdIn,
    output logic            busy,
    output logic            done,
    output logic [4:0]      Rd,
    output logic            RegWrite,
    output logic [XLEN-1:0] WriteData
);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = '1;

    state_e          r_state, w_state_next;
    logic [4:0]      r_count;
    logic [XLEN-1:0] r_rem;      // partial remainder (divide) / product high half (multiply)
    logic [XLEN-1:0] r_quo;      // dividend->quotient (divide) / multiplier->product low half
    logic [XLEN-1:0] r_dvs;      // divisor (divide) / multiplicand (multiply)
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd_pend;
    logic [4:0]      r_rd;
    logic            r_neg_q;    // negate quotient / product at the end
    logic            r_neg_r;    // negate remainder at the end
    logic            r_sel_rem;
    logic            r_wen_ok;
`ifdef MULDIV_MUL_EN
    logic            r_is_mul;
    logic            r_mul_lo;
`endif

    // ------------------------------------------------------------------
    // Operand decode at accept
    // ------------------------------------------------------------------
    logic            w_accept, w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2;
    logic            w_div_zero, w_div_ovf, w_fast;
    logic [XLEN-1:0] w_mag1, w_mag2, w_fast_data;

    always_comb begin
        w_is_div    = funct3[2];
        // Divide: DIV/REM signed. Multiply: MULH both signed, MULHSU rs1 only.
        w_sgn1      = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        w_sgn2      = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        w_neg1      = w_sgn1 & Rs1Data[XLEN-1];
        w_neg2      = w_sgn2 & Rs2Data[XLEN-1];
        w_mag1      = w_neg1 ? -Rs1Data : Rs1Data;
        w_mag2      = w_neg2 ? -Rs2Data : Rs2Data;
        w_div_zero  = w_is_div && (Rs2Data == '0);
        w_div_ovf   = w_is_div && ~funct3[0] && (Rs1Data == MinNeg) && (Rs2Data == AllOnes);
        w_fast_data = '0;
        if (w_div_zero) begin
            w_fast_data = funct3[1] ? Rs1Data : AllOnes;
        end else if (w_div_ovf) begin
            w_fast_data = funct3[1] ? '0 : MinNeg;
        end
`ifdef MULDIV_MUL_EN
        w_fast      = w_div_zero | w_div_ovf;
`else
        // Multiply encodings still complete so the issue logic never hangs.
        w_fast      = w_div_zero | w_div_ovf | ~w_is_div;
`endif
        w_accept    = start && (r_state != StCalc);
    end

    // ------------------------------------------------------------------
    // One iteration step and final sign fix
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_rem_sh, w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_div_rem, w_div_quo, w_q_fix, w_r_fix;
    logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_result;
`ifdef MULDIV_MUL_EN
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
`endif

    always_comb begin
        // Restoring division: shift in the next dividend bit, subtract if it fits.
        w_rem_sh  = {r_rem, r_quo[XLEN-1]};
        w_diff    = w_rem_sh - {1'b0, r_dvs};
        w_ge      = ~w_diff[XLEN];
        w_div_rem = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_div_quo = {r_quo[XLEN-2:0], w_ge};
        w_q_fix   = r_neg_q ? -w_div_quo : w_div_quo;
        w_r_fix   = r_neg_r ? -w_div_rem : w_div_rem;
        w_rem_nxt = w_div_rem;
        w_quo_nxt = w_div_quo;
        w_result  = r_sel_rem ? w_r_fix : w_q_fix;
`ifdef MULDIV_MUL_EN
        // Shift-add: add multiplicand to the high half when the multiplier
        // LSB is set, then shift the whole 64-bit product right by one.
        w_sum      = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : '0);
        w_prod     = {w_sum, r_quo[XLEN-1:1]};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
        if (r_is_mul) begin
            w_rem_nxt = w_prod[2*XLEN-1:XLEN];
            w_quo_nxt = w_prod[XLEN-1:0];
            w_result  = r_mul_lo ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            StIdle, StFinish: begin
                if (w_accept) begin
                    w_state_next = w_fast ? StFinish : StCalc;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StCalc: begin
                if (r_count == 5'd31) begin
                    w_state_next = StFinish;
                end
            end
            default: w_state_next = StIdle;
        endcase
        busy      = (r_state == StCalc);
        done      = (r_state == StFinish);
        Rd        = r_rd;
        WriteData = r_wdata;
        RegWrite  = done & r_wen_ok & (r_rd != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_wdata   <= '0;
            r_rd_pend <= '0;
            r_rd      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_wen_ok  <= 1'b0;
`ifdef MULDIV_MUL_EN
            r_is_mul  <= 1'b0;
            r_mul_lo  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_count   <= '0;
                r_rd_pend <= RdIn;
                r_sel_rem <= funct3[1];
                r_neg_q   <= w_neg1 ^ w_neg2;
                r_neg_r   <= w_neg1;
                r_rem     <= '0;
`ifdef MULDIV_MUL_EN
                r_is_mul  <= ~w_is_div;
                r_mul_lo  <= (funct3[1:0] == 2'b00);
                r_quo     <= w_is_div ? w_mag1 : w_mag2;
                r_dvs     <= w_is_div ? w_mag2 : w_mag1;
`else
                r_quo     <= w_mag1;
                r_dvs     <= w_mag2;
`endif
                if (w_fast) begin
                    r_wdata  <= w_fast_data;
                    r_rd     <= RdIn;
                    r_wen_ok <= w_is_div;
                end
            end else if (r_state == StCalc) begin
                r_count <= r_count + 5'd1;
                r_rem   <= w_rem_nxt;
                r_quo   <= w_quo_nxt;
                if (r_count == 5'd31) begin
                    r_wdata  <= w_result;
                    r_rd     <= r_rd_pend;
                    r_wen_ok <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed corner cases
// plus randomized operations compared with an arithmetic reference model.

`timescale 1ns / 1ps

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] Rs1Data, Rs2Data;
    logic [4:0]  RdIn;
    logic        busy, done, RegWrite;
    logic [4:0]  Rd;
    logic [31:0] WriteData;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .Rs1Data   (Rs1Data),
        .Rs2Data   (Rs2Data),
        .RdIn      (RdIn),
        .busy      (busy),
        .done      (done),
        .Rd        (Rd),
        .RegWrite  (RegWrite),
        .WriteData (WriteData)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] data;
        logic        wen;
        int          lat;   // edges from accept until done is seen
    } res_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain RV32M arithmetic.
    function automatic res_t model(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        res_t r;
        r.wen = 1'b1;
        r.lat = 32;
        r.data = '0;
        if (f3[2]) begin
            if (b == 32'd0) begin
                r.lat  = 0;
                r.data = f3[1] ? a : 32'hFFFFFFFF;
            end else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                r.lat  = 0;
                r.data = f3[1] ? 32'd0 : 32'h80000000;
            end else if (!f3[0]) begin
                r.data = f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
            end else begin
                r.data = f3[1] ? a % b : a / b;
            end
        end else begin
`ifdef MULDIV_MUL_EN
            begin : mul_ref
                logic [63:0] ea, eb, p;
                ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
                eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
                p  = ea * eb;
                r.data = (f3 == 3'b000) ? p[31:0] : p[63:32];
            end
`else
            r.lat  = 0;
            r.wen  = 1'b0;
            r.data = 32'd0;
`endif
        end
        return r;
    endfunction

    // Present a request, let the accept edge pass, then scramble the inputs.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        funct3  = f3;
        Rs1Data = a;
        Rs2Data = b;
        RdIn    = rd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        Rs1Data = $urandom;
        Rs2Data = $urandom;
        funct3  = 3'($urandom);
        RdIn    = 5'($urandom);
    endtask

    // Wait for done (k0 edges already elapsed since accept) and check everything.
    task automatic expect_done(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int k0, input string tag);
        res_t m;
        int   k;
        m = model(f3, a, b);
        k = k0;
        check_eq({tag, "/busy"}, 32'(busy), 32'(m.lat > k0));
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "/latency"}, 32'(k), 32'(m.lat));
        check_eq({tag, "/data"}, WriteData, m.data);
        check_eq({tag, "/rd"}, 32'(Rd), 32'(rd));
        check_eq({tag, "/regwrite"}, 32'(RegWrite), 32'(m.wen && rd != 5'd0));
        check_eq({tag, "/busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int gap, input string tag);
        if (gap > 0) begin
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            check_eq({tag, "/idle_done"}, 32'(done), 32'd0);
        end
        issue(f3, a, b, rd);
        expect_done(f3, a, b, rd, 0, tag);
    endtask

    initial begin
        logic        seen_done, seen_wr;
        logic [2:0]  f3;
        logic [31:0] a, b;
        start   = 1'b0;
        funct3  = '0;
        Rs1Data = '0;
        Rs2Data = '0;
        RdIn    = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset/busy", 32'(busy), 32'd0);
        check_eq("reset/done", 32'(done), 32'd0);
        check_eq("reset/regwrite", 32'(RegWrite), 32'd0);
        check_eq("reset/rd", 32'(Rd), 32'd0);
        check_eq("reset/data", WriteData, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(3'b101, 32'd100, 32'd7, 5'd5, 1, "divu_100_7");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 1, "rem_m7_2");
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 2, "div_m7_2");
        run_op(3'b100, 32'd123, 32'd0, 5'd8, 1, "div_by0");
        run_op(3'b111, 32'd123, 32'd0, 5'd8, 1, "remu_by0");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd9, 0, "rem_ovf");
        run_op(3'b101, 32'd1000, 32'd3, 5'd0, 1, "divu_rd0");
`ifdef MULDIV_MUL_EN
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1, "mulhu_ff");
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1, "mul_ff");
`else
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1, "mul_off");
`endif

        // Back-to-back: second start held into the first FINISH cycle.
        run_op(3'b101, 32'hFFFFFFFF, 32'd3, 5'd10, 1, "b2b_first");
        run_op(3'b100, 32'h7FFFFFFF, 32'hFFFFFFF0, 5'd11, 0, "b2b_second");

        // A start during CALC must be ignored.
        issue(3'b101, 32'd1000, 32'd9, 5'd7);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        funct3  = 3'b100;
        Rs1Data = 32'd55;
        Rs2Data = 32'd0;
        RdIn    = 5'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        expect_done(3'b101, 32'd1000, 32'd9, 5'd7, 6, "calc_ignore");

        // Reset in the middle of an iteration.
        @(posedge clk);
        #1;
        issue(3'b101, 32'hDEADBEEF, 32'h1234, 5'd12);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check_eq("midrst/busy", 32'(busy), 32'd0);
        check_eq("midrst/done", 32'(done), 32'd0);
        check_eq("midrst/regwrite", 32'(RegWrite), 32'd0);
        check_eq("midrst/rd", 32'(Rd), 32'd0);
        check_eq("midrst/data", WriteData, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        seen_wr   = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
            if (RegWrite) seen_wr = 1'b1;
        end
        check_eq("midrst/no_done", 32'(seen_done), 32'd0);
        check_eq("midrst/no_write", 32'(seen_wr), 32'd0);
        check_eq("midrst/data_after", WriteData, 32'd0);

        // Randomized operations with a bias toward the corner cases.
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin
                    a = 32'h80000000;
                    b = 32'hFFFFFFFF;
                end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                4: b = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(f3, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
